// File: rtl/ppu_pkg.sv
// Shared PPU definitions: sprite-DMA state encoding and OAM DMA constants.
package ppu_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } dma_state_t;

    localparam logic [15:0] OAM_DMA_REG = 16'h4014;
    localparam int          OAM_BYTES   = 256;

endpackage

// File: rtl/ppu_oam_dma.sv
// Sprite DMA sequencer: copies CPU page {P,00}..{P,FF} into OAM starting at OAMADDR.
// Optional macro OAM_DMA_ODD_ALIGN_EN adds the odd-cycle ALIGN dummy cycle.
module ppu_oam_dma
    import ppu_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR = OAM_DMA_REG,
    parameter int          XFER_BYTES   = OAM_BYTES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_we,
    input  logic [7:0]  cpu_wdata,
    input  logic [7:0]  oam_addr_start,
    input  logic        cpu_odd_cycle,
    input  logic [7:0]  mem_rd_data,
    output logic        cpu_stall,
    output logic        mem_rd_en,
    output logic [15:0] mem_rd_addr,
    output logic        oam_en,
    output logic        oam_rw,
    output logic [5:0]  spr_select,
    output logic [1:0]  byte_select,
    output logic [7:0]  oam_wdata,
    output logic        dma_busy
);

    localparam logic [7:0] LAST_CNT = 8'(XFER_BYTES - 1);

    dma_state_t  r_state;
    logic [7:0]  r_page;
    logic [7:0]  r_ptr;
    logic [7:0]  r_cnt;
    logic        r_stall;
    logic        r_rd_en;
    logic [15:0] r_rd_addr;
    logic        r_oam_en;
    logic [7:0]  r_oam_sel;

    dma_state_t  w_state_nxt;
    logic [7:0]  w_page_nxt;
    logic [7:0]  w_ptr_nxt;
    logic [7:0]  w_cnt_nxt;
    logic        w_trigger;

    assign w_trigger = cpu_we && (cpu_addr == DMA_REG_ADDR);

`ifndef OAM_DMA_ODD_ALIGN_EN
    logic w_unused_odd;
    assign w_unused_odd = cpu_odd_cycle;
`endif

    // Next-state and transfer-counter logic
    always_comb begin
        w_state_nxt = r_state;
        w_page_nxt  = r_page;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_trigger) begin
                    w_state_nxt = HALT;
                    w_page_nxt  = cpu_wdata;
                    w_ptr_nxt   = oam_addr_start;
                    w_cnt_nxt   = 8'h00;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            HALT: begin
`ifdef OAM_DMA_ODD_ALIGN_EN
                if (cpu_odd_cycle) begin
                    w_state_nxt = ALIGN;
                end else begin
                    w_state_nxt = READ;
                end
`else
                w_state_nxt = READ;
`endif
            end
`ifdef OAM_DMA_ODD_ALIGN_EN
            ALIGN: w_state_nxt = READ;
`endif
            READ:  w_state_nxt = WRITE;
            WRITE: begin
                w_ptr_nxt = r_ptr + 8'h01;
                w_cnt_nxt = r_cnt + 8'h01;
                if (r_cnt == LAST_CNT) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = READ;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, counters and outputs registered from the next-state decode
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_page    <= 8'h00;
            r_ptr     <= 8'h00;
            r_cnt     <= 8'h00;
            r_stall   <= 1'b0;
            r_rd_en   <= 1'b0;
            r_rd_addr <= 16'h0000;
            r_oam_en  <= 1'b0;
            r_oam_sel <= 8'h00;
        end else begin
            r_state   <= w_state_nxt;
            r_page    <= w_page_nxt;
            r_ptr     <= w_ptr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_stall   <= (w_state_nxt != IDLE);
            r_rd_en   <= (w_state_nxt == READ);
            r_rd_addr <= (w_state_nxt == READ) ? {w_page_nxt, w_cnt_nxt} : 16'h0000;
            r_oam_en  <= (w_state_nxt == WRITE);
            r_oam_sel <= (w_state_nxt == WRITE) ? w_ptr_nxt : 8'h00;
        end
    end

    // Read data arrives the cycle after READ, so it is forwarded straight into OAM
    assign oam_wdata   = (r_state == WRITE) ? mem_rd_data : 8'h00;
    assign cpu_stall   = r_stall;
    assign dma_busy    = r_stall;
    assign mem_rd_en   = r_rd_en;
    assign mem_rd_addr = r_rd_addr;
    assign oam_en      = r_oam_en;
    assign oam_rw      = 1'b0;
    assign spr_select  = r_oam_sel[7:2];
    assign byte_select = r_oam_sel[1:0];

endmodule

// File: tb/tb_ppu_oam_dma.sv
// Directed bench for ppu_oam_dma: decode table plus hand-written transfer sequences.
module tb_ppu_oam_dma;

`ifdef OAM_DMA_ODD_ALIGN_EN
    localparam int ALIGN_EXTRA = 1;
`else
    localparam int ALIGN_EXTRA = 0;
`endif
    localparam int XFER_LEN = 514;

    logic        clk;
    logic        rst_n;
    logic [15:0] cpu_addr;
    logic        cpu_we;
    logic [7:0]  cpu_wdata;
    logic [7:0]  oam_addr_start;
    logic        cpu_odd_cycle;
    logic [7:0]  mem_rd_data;
    logic        cpu_stall;
    logic        mem_rd_en;
    logic [15:0] mem_rd_addr;
    logic        oam_en;
    logic        oam_rw;
    logic [5:0]  spr_select;
    logic [1:0]  byte_select;
    logic [7:0]  oam_wdata;
    logic        dma_busy;

    ppu_oam_dma dut (
        .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_we(cpu_we),
        .cpu_wdata(cpu_wdata), .oam_addr_start(oam_addr_start),
        .cpu_odd_cycle(cpu_odd_cycle), .mem_rd_data(mem_rd_data),
        .cpu_stall(cpu_stall), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .oam_en(oam_en), .oam_rw(oam_rw), .spr_select(spr_select),
        .byte_select(byte_select), .oam_wdata(oam_wdata), .dma_busy(dma_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory returns addr[7:0]^5A one cycle after a read request, junk otherwise
    always @(posedge clk) begin
        mem_rd_data <= mem_rd_en ? (mem_rd_addr[7:0] ^ 8'h5A) : 8'hEE;
    end

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [7:0]  wdata;
        logic        exp_busy;
    } vec_t;

    vec_t       vecs[5];
    int         n_checks;
    int         n_fail;
    int         len, n_wr, first_rd, addr_err, ctl_err, ord_err, data_err;
    logic       timeout;
    logic [7:0] log_ptr[0:255];
    logic [7:0] log_data[0:255];
    logic [7:0] oam_mem[0:255];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " cpu_stall"},   32'(cpu_stall),   32'd0);
        chk({tag, " mem_rd_en"},   32'(mem_rd_en),   32'd0);
        chk({tag, " mem_rd_addr"}, 32'(mem_rd_addr), 32'd0);
        chk({tag, " oam_en"},      32'(oam_en),      32'd0);
        chk({tag, " oam_rw"},      32'(oam_rw),      32'd0);
        chk({tag, " spr_select"},  32'(spr_select),  32'd0);
        chk({tag, " byte_select"}, 32'(byte_select), 32'd0);
        chk({tag, " oam_wdata"},   32'(oam_wdata),   32'd0);
        chk({tag, " dma_busy"},    32'(dma_busy),    32'd0);
    endtask

    // Trigger a transfer and observe it at each negedge until dma_busy falls.
    task automatic run_xfer(input logic [7:0] page, input logic [7:0] start, input logic odd,
                            input int retrig_k, input int reset_k);
        int exp_cnt;
        exp_cnt = 0; len = 0; n_wr = 0; first_rd = -1;
        addr_err = 0; ctl_err = 0; timeout = 1'b0;
        @(negedge clk);
        cpu_addr = 16'h4014; cpu_we = 1'b1; cpu_wdata = page;
        oam_addr_start = start; cpu_odd_cycle = odd;
        for (int k = 1; k <= 1000; k++) begin
            @(negedge clk);
            cpu_we = 1'b0; cpu_addr = 16'h0000;
            if (!dma_busy) break;
            len++;
            if (cpu_stall !== dma_busy) ctl_err++;
            if (mem_rd_en) begin
                if (first_rd < 0) first_rd = k;
                if (mem_rd_addr !== {page, 8'(exp_cnt)}) addr_err++;
                if (oam_en) ctl_err++;
                exp_cnt++;
            end
            if (oam_en) begin
                if (oam_rw) ctl_err++;
                if (n_wr < 256) begin
                    log_ptr[n_wr]  = {spr_select, byte_select};
                    log_data[n_wr] = oam_wdata;
                end
                oam_mem[{spr_select, byte_select}] = oam_wdata;
                n_wr++;
            end
            if (k == retrig_k) begin
                cpu_addr = 16'h4014; cpu_we = 1'b1; cpu_wdata = 8'h77;
            end
            if (k == reset_k) begin
                rst_n = 1'b0;
                return;
            end
            if (k == 1000) timeout = 1'b1;
        end
    endtask

    // Order: write j goes to start+j; data: write j carries source byte j ^ 5A.
    task automatic score(input logic [7:0] start);
        ord_err = 0; data_err = 0;
        for (int j = 0; j < 256; j++) begin
            if (log_ptr[j] !== 8'(start + 8'(j))) ord_err++;
            if (log_data[j] !== (8'(j) ^ 8'h5A)) data_err++;
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        rst_n = 1'b0; cpu_addr = 16'h0000; cpu_we = 1'b0; cpu_wdata = 8'h00;
        oam_addr_start = 8'h00; cpu_odd_cycle = 1'b0;
        for (int i = 0; i < 256; i++) oam_mem[i] = 8'h00;

        vecs[0] = '{16'h4013, 1'b1, 8'h02, 1'b0};
        vecs[1] = '{16'h2004, 1'b1, 8'h02, 1'b0};
        vecs[2] = '{16'h4014, 1'b0, 8'h02, 1'b0};
        vecs[3] = '{16'h4015, 1'b1, 8'h02, 1'b0};
        vecs[4] = '{16'hC014, 1'b1, 8'h02, 1'b0};

        repeat (3) @(negedge clk);
        chk_idle("reset");
        rst_n = 1'b1;

        for (int v = 0; v < 5; v++) begin
            @(negedge clk);
            cpu_addr = vecs[v].addr; cpu_we = vecs[v].we; cpu_wdata = vecs[v].wdata;
            @(negedge clk);
            cpu_we = 1'b0; cpu_addr = 16'h0000;
            chk($sformatf("decode[%0d] dma_busy", v), 32'(dma_busy), 32'(vecs[v].exp_busy));
            chk($sformatf("decode[%0d] cpu_stall", v), 32'(cpu_stall), 32'(vecs[v].exp_busy));
        end

        // Basic page 02 transfer from OAMADDR 00
        run_xfer(8'h02, 8'h00, 1'b0, -1, -1);
        score(8'h00);
        chk("basic timeout", 32'(timeout), 32'd0);
        chk("basic length", 32'(len), 32'(XFER_LEN));
        chk("basic writes", 32'(n_wr), 32'd256);
        chk("basic first read", 32'(first_rd), 32'd2);
        chk("basic read addr", 32'(addr_err), 32'd0);
        chk("basic control", 32'(ctl_err), 32'd0);
        chk("basic order", 32'(ord_err), 32'd0);
        chk("basic data", 32'(data_err), 32'd0);
        chk("basic oam[0]", 32'(oam_mem[0]), 32'h5A);
        chk("basic oam[FF]", 32'(oam_mem[255]), 32'hA5);
        chk_idle("after basic");

        // Start at FC: writes wrap from sprite 3F to sprite 00
        run_xfer(8'h03, 8'hFC, 1'b0, -1, -1);
        chk("wrap length", 32'(len), 32'(XFER_LEN));
        chk("wrap read addr", 32'(addr_err), 32'd0);
        chk("wrap first spr", 32'(log_ptr[0][7:2]), 32'h3F);
        chk("wrap first byte", 32'(log_ptr[0][1:0]), 32'h0);
        chk("wrap first data", 32'(log_data[0]), 32'h5A);
        chk("wrap 5th spr", 32'(log_ptr[4][7:2]), 32'h00);
        chk("wrap 5th byte", 32'(log_ptr[4][1:0]), 32'h0);
        chk("wrap 5th data", 32'(log_data[4]), 32'h5E);
        score(8'hFC);
        chk("wrap order", 32'(ord_err), 32'd0);

        // Second $4014 write mid-transfer is ignored
        run_xfer(8'h02, 8'h10, 1'b0, 100, -1);
        chk("retrig length", 32'(len), 32'(XFER_LEN));
        chk("retrig writes", 32'(n_wr), 32'd256);
        chk("retrig read addr", 32'(addr_err), 32'd0);
        @(negedge clk);
        chk("retrig no restart", 32'(dma_busy), 32'd0);

        // Reset mid-transfer aborts immediately, then a fresh transfer is complete
        run_xfer(8'h05, 8'h00, 1'b0, -1, 200);
        @(negedge clk);
        chk_idle("mid reset");
        rst_n = 1'b1;
        run_xfer(8'h06, 8'h40, 1'b0, -1, -1);
        score(8'h40);
        chk("post-reset length", 32'(len), 32'(XFER_LEN));
        chk("post-reset writes", 32'(n_wr), 32'd256);
        chk("post-reset read addr", 32'(addr_err), 32'd0);
        chk("post-reset data", 32'(data_err), 32'd0);

        // Odd-cycle alignment
        run_xfer(8'h02, 8'h00, 1'b1, -1, -1);
        chk("odd length", 32'(len), 32'(XFER_LEN + ALIGN_EXTRA));
        chk("odd first read", 32'(first_rd), 32'(2 + ALIGN_EXTRA));
        chk("odd writes", 32'(n_wr), 32'd256);
        run_xfer(8'h02, 8'h00, 1'b0, -1, -1);
        chk("even length", 32'(len), 32'(XFER_LEN));
        chk("even first read", 32'(first_rd), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
